// File: rtl/fpga_cmd_rx.sv
// fpga_cmd_rx - SPI command receiver, pck0 domain.
//
// Samples the ARM's asynchronous spck/mosi/ncs through SYNC_STAGES-deep
// synchronizers. It assembles CMD_WIDTH-bit frames (MSB first) and decodes
// them into the configuration word and the ADC clock divisor. All outputs
// change synchronously to pck0, so the downstream mode muxes never glitch.
//
// Optional feature macro: CMD_RX_DIVISOR_EN
//   defined   : opcode 4'b0010 writes the divisor register.
//   undefined : no divisor register; divisor is tied to 8'd95 and
//               opcode 4'b0010 is ignored like any unknown opcode.
//
// Ports:
//   pck0        in   system clock, rising edge
//   nrst        in   asynchronous active-low reset
//   spck        in   SPI clock (asynchronous)
//   mosi        in   SPI data, MSB first (asynchronous)
//   ncs         in   SPI chip select, active low (asynchronous)
//   conf_word   out  [7:0] configuration register (reset 8'hE0)
//   major_mode  out  [2:0] conf_word[7:5]
//   divisor     out  [7:0] ADC clock divisor (reset 8'd95)
//   conf_valid  out  one-cycle pulse on every conf_word write
//   frame_err   out  one-cycle pulse when a frame has the wrong bit count
module fpga_cmd_rx #(
    parameter int CMD_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       pck0,
    input  logic       nrst,
    input  logic       spck,
    input  logic       mosi,
    input  logic       ncs,
    output logic [7:0] conf_word,
    output logic [2:0] major_mode,
    output logic [7:0] divisor,
    output logic       conf_valid,
    output logic       frame_err
);

    localparam int              CNT_W    = $clog2(CMD_WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CMD_WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CMD_WIDTH + 1);
    localparam logic [7:0]      CONF_RST = 8'hE0;
    localparam logic [7:0]      DIV_RST  = 8'd95;
    localparam logic [3:0]      OP_CONF  = 4'b0001;
    localparam logic [3:0]      OP_DIV   = 4'b0010;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2
    } state_t;

    // Synchronizers. The ncs chain and its delayed copy reset low, so a
    // reset released mid-frame can never produce a false falling edge;
    // the FSM must first see ncs_s high.
    logic [SYNC_STAGES-1:0] r_spck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_ncs_sync;
    logic                   r_spck_d;
    logic                   r_ncs_d;

    always_ff @(posedge pck0 or negedge nrst) begin
        if (!nrst) begin
            r_spck_sync <= '0;
            r_mosi_sync <= '0;
            r_ncs_sync  <= '0;
            r_spck_d    <= 1'b0;
            r_ncs_d     <= 1'b0;
        end else begin
            r_spck_sync <= {r_spck_sync[SYNC_STAGES-2:0], spck};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
            r_spck_d    <= r_spck_sync[SYNC_STAGES-1];
            r_ncs_d     <= r_ncs_sync[SYNC_STAGES-1];
        end
    end

    logic w_spck_s, w_mosi_s, w_ncs_s;
    logic w_spck_rise, w_ncs_rise, w_ncs_fall;

    assign w_spck_s    = r_spck_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
    assign w_spck_rise = w_spck_s & ~r_spck_d;
    assign w_ncs_rise  = w_ncs_s & ~r_ncs_d;
    assign w_ncs_fall  = ~w_ncs_s & r_ncs_d;

    state_t                 r_state;
    logic [CMD_WIDTH-1:0]   r_shift;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [7:0]             r_conf_word;
    logic                   r_conf_valid;
    logic                   r_frame_err;
    logic [3:0]             w_opcode;

    assign w_opcode = r_shift[CMD_WIDTH-1 -: 4];

`ifdef CMD_RX_DIVISOR_EN
    logic [7:0] r_divisor;
    assign divisor = r_divisor;
`else
    assign divisor = DIV_RST;
`endif

    always_ff @(posedge pck0 or negedge nrst) begin
        if (!nrst) begin
            r_state      <= WAIT_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_conf_word  <= CONF_RST;
            r_conf_valid <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef CMD_RX_DIVISOR_EN
            r_divisor    <= DIV_RST;
`endif
        end else begin
            r_conf_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                WAIT_IDLE: begin
                    if (w_ncs_s) r_state <= IDLE;
                end
                IDLE: begin
                    if (w_ncs_fall) begin
                        r_state   <= SHIFT;
                        r_shift   <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    // Frame end wins over a coincident spck edge; that bit is dropped.
                    if (w_ncs_rise) begin
                        r_state <= IDLE;
                        if (r_bit_cnt != CNT_FULL) begin
                            r_frame_err <= 1'b1;
                        end else if (w_opcode == OP_CONF) begin
                            r_conf_word  <= r_shift[7:0];
                            r_conf_valid <= 1'b1;
                        end
`ifdef CMD_RX_DIVISOR_EN
                        else if (w_opcode == OP_DIV) begin
                            r_divisor <= r_shift[7:0];
                        end
`endif
                    end else if (w_spck_rise && !w_ncs_s) begin
                        r_shift <= {r_shift[CMD_WIDTH-2:0], w_mosi_s};
                        // Saturate one past full so overruns stay distinguishable.
                        if (r_bit_cnt != CNT_SAT) r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: r_state <= WAIT_IDLE;
            endcase
        end
    end

    assign conf_word  = r_conf_word;
    assign major_mode = r_conf_word[7:5];
    assign conf_valid = r_conf_valid;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_fpga_cmd_rx.sv
// Directed bench for fpga_cmd_rx (CMD_WIDTH=16, SYNC_STAGES=2).
// spck runs at pck0/8; every frame end is watched for 8 cycles so the
// pulse count and pulse position (edge index after ncs rises) are checked.
module tb_fpga_cmd_rx;

    logic       pck0 = 1'b0;
    logic       nrst = 1'b0;
    logic       spck = 1'b0;
    logic       mosi = 1'b0;
    logic       ncs  = 1'b1;
    logic [7:0] conf_word;
    logic [2:0] major_mode;
    logic [7:0] divisor;
    logic       conf_valid;
    logic       frame_err;

    int n_chk  = 0;
    int n_pass = 0;
    int cv_cnt, fe_cnt, cv_at, fe_at;

`ifdef CMD_RX_DIVISOR_EN
    localparam logic [7:0] DIV_AFTER = 8'h20;
`else
    localparam logic [7:0] DIV_AFTER = 8'd95;
`endif

    fpga_cmd_rx #(.CMD_WIDTH(16), .SYNC_STAGES(2)) dut (
        .pck0       (pck0),
        .nrst       (nrst),
        .spck       (spck),
        .mosi       (mosi),
        .ncs        (ncs),
        .conf_word  (conf_word),
        .major_mode (major_mode),
        .divisor    (divisor),
        .conf_valid (conf_valid),
        .frame_err  (frame_err)
    );

    always #5 pck0 = ~pck0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge pck0);
        #1;
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        wait_cyc(4);
        spck = 1'b1;
        wait_cyc(4);
        spck = 1'b0;
    endtask

    // Raise ncs (optionally together with a final spck rise), then watch
    // 8 edges; edge 0 is the first pck0 edge that samples ncs high.
    task automatic end_frame(input logic with_spck);
        if (with_spck) spck = 1'b1;
        ncs = 1'b1;
        cv_cnt = 0; fe_cnt = 0; cv_at = -1; fe_at = -1;
        @(posedge pck0);
        for (int k = 0; k < 8; k++) begin
            @(negedge pck0);
            if (conf_valid) begin cv_cnt++; if (cv_at < 0) cv_at = k; end
            if (frame_err)  begin fe_cnt++; if (fe_at < 0) fe_at = k; end
        end
        @(posedge pck0); #1;
        spck = 1'b0;
    endtask

    task automatic frame(input logic [31:0] v, input int n, input logic simul);
        ncs = 1'b0;
        wait_cyc(4);
        for (int i = n - 1; i >= (simul ? 1 : 0); i--) send_bit(v[i]);
        if (simul) begin
            mosi = v[0];
            wait_cyc(4);
        end else begin
            wait_cyc(4);
        end
        end_frame(simul);
    endtask

    initial begin
        wait_cyc(3);
        @(negedge pck0);
        chk("rst_conf",  conf_word, 8'hE0);
        chk("rst_major", major_mode, 3'b111);
        chk("rst_div",   divisor, 8'd95);
        chk("rst_cv",    conf_valid, 1'b0);
        chk("rst_fe",    frame_err, 1'b0);
        @(posedge pck0); #1;
        nrst = 1'b1;
        wait_cyc(6);

        frame(32'h1043, 16, 1'b0);
        chk("f1043_conf",  conf_word, 8'h43);
        chk("f1043_major", major_mode, 3'b010);
        chk("f1043_cvcnt", cv_cnt, 1);
        chk("f1043_cvat",  cv_at, 2);
        chk("f1043_fe",    fe_cnt, 0);

        frame(32'h2020, 16, 1'b0);
        chk("f2020_div",  divisor, DIV_AFTER);
        chk("f2020_conf", conf_word, 8'h43);
        chk("f2020_cv",   cv_cnt, 0);
        chk("f2020_fe",   fe_cnt, 0);

        frame(32'h10FF >> 1, 15, 1'b0);
        chk("short_fe",   fe_cnt, 1);
        chk("short_feat", fe_at, 2);
        chk("short_conf", conf_word, 8'h43);
        chk("short_cv",   cv_cnt, 0);

        frame({15'd0, 16'h10FF, 1'b1}, 17, 1'b0);
        chk("over_fe",   fe_cnt, 1);
        chk("over_conf", conf_word, 8'h43);
        chk("over_cv",   cv_cnt, 0);

        frame(32'h7055, 16, 1'b0);
        chk("unk_conf", conf_word, 8'h43);
        chk("unk_div",  divisor, DIV_AFTER);
        chk("unk_cv",   cv_cnt, 0);
        chk("unk_fe",   fe_cnt, 0);

        // Reset in the middle of a frame, released with ncs still low.
        ncs = 1'b0;
        wait_cyc(4);
        for (int i = 7; i >= 0; i--) send_bit(8'h10 >> i);
        nrst = 1'b0;
        wait_cyc(3);
        nrst = 1'b1;
        chk("mid_rst_conf", conf_word, 8'hE0);
        for (int i = 7; i >= 0; i--) send_bit(8'hA5 >> i);
        wait_cyc(4);
        end_frame(1'b0);
        chk("mid_conf", conf_word, 8'hE0);
        chk("mid_cv",   cv_cnt, 0);
        chk("mid_fe",   fe_cnt, 0);

        frame(32'h10A5, 16, 1'b0);
        chk("a5_conf",  conf_word, 8'hA5);
        chk("a5_major", major_mode, 3'b101);
        chk("a5_cv",    cv_cnt, 1);
        chk("a5_div",   divisor, 8'd95);

        // Last spck edge coincident with ncs rise: bit dropped, 15 counted.
        frame(32'h1011, 16, 1'b1);
        chk("sim_fe",   fe_cnt, 1);
        chk("sim_cv",   cv_cnt, 0);
        chk("sim_conf", conf_word, 8'hA5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
